// File: rtl/alu_serial_ctrl_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcodes, FSM states, slice selects
// and the opcode-to-slice-control decode.
package alu_serial_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_SUM  = 2'd0,
        SEL_NAND = 2'd1,
        SEL_NOR  = 2'd2,
        SEL_XOR  = 2'd3
    } slice_sel_t;

    typedef struct packed {
        logic       inv_a;
        logic       inv_b;
        slice_sel_t sel;
        logic       arith;
    } slice_ctl_t;

    // AND/OR are built from NOR/NAND with both inputs inverted (De Morgan).
    function automatic slice_ctl_t decode_op(input alu_op_t op);
        slice_ctl_t c;
        c = '{inv_a: 1'b0, inv_b: 1'b0, sel: SEL_SUM, arith: 1'b0};
        case (op)
            OP_ADD:  c = '{inv_a: 1'b0, inv_b: 1'b0, sel: SEL_SUM,  arith: 1'b1};
            OP_SUB:  c = '{inv_a: 1'b0, inv_b: 1'b1, sel: SEL_SUM,  arith: 1'b1};
            OP_SLT:  c = '{inv_a: 1'b0, inv_b: 1'b1, sel: SEL_SUM,  arith: 1'b1};
            OP_AND:  c = '{inv_a: 1'b1, inv_b: 1'b1, sel: SEL_NOR,  arith: 1'b0};
            OP_OR:   c = '{inv_a: 1'b1, inv_b: 1'b1, sel: SEL_NAND, arith: 1'b0};
            OP_XOR:  c = '{inv_a: 1'b0, inv_b: 1'b0, sel: SEL_XOR,  arith: 1'b0};
            OP_NAND: c = '{inv_a: 1'b0, inv_b: 1'b0, sel: SEL_NAND, arith: 1'b0};
            OP_NOR:  c = '{inv_a: 1'b0, inv_b: 1'b0, sel: SEL_NOR,  arith: 1'b0};
            default: c = '{inv_a: 1'b0, inv_b: 1'b0, sel: SEL_SUM,  arith: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_slice.sv
// Combinational 1-bit ALU slice: optional input inversion, then sum/NAND/NOR/XOR
// select, plus full-adder carry out.
module alu_serial_slice
    import alu_serial_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       inv_a,
    input  logic       inv_b,
    input  logic [1:0] sel,
    output logic       y,
    output logic       cout
);

    logic ai;
    logic bi;

    assign ai   = a ^ inv_a;
    assign bi   = b ^ inv_b;
    assign cout = (ai & bi) | (cin & (ai ^ bi));

    always_comb begin
        y = 1'b0;
        case (slice_sel_t'(sel))
            SEL_SUM:  y = ai ^ bi ^ cin;
            SEL_NAND: y = ~(ai & bi);
            SEL_NOR:  y = ~(ai | bi);
            SEL_XOR:  y = ai ^ bi;
            default:  y = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: streams WIDTH-bit operands LSB-first through one slice.
// Define ALU_SERIAL_FLAGS_EN to enable carry/overflow flags and overflow-corrected SLT.
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request
// RUN     | one operand bit per cycle through the slice, cnt = bit index
// DONE    | res_valid=1, result held until res_ready
module alu_serial_ctrl
    import alu_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_carry,
    output logic             res_ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    alu_op_t          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sh_q;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic             zacc_q;

    slice_ctl_t       ctl;
    logic             slice_y;
    logic             slice_cout;
    logic [WIDTH-1:0] next_sh;
    logic             fin_zero;
    logic             fin_carry;
    logic             fin_ovf;
    logic             slt_bit;

    assign ctl = decode_op(op_q);

    alu_serial_slice u_slice (
        .a     (a_q[cnt]),
        .b     (b_q[cnt]),
        .cin   (carry_q),
        .inv_a (ctl.inv_a),
        .inv_b (ctl.inv_b),
        .sel   (ctl.sel),
        .y     (slice_y),
        .cout  (slice_cout)
    );

    assign next_sh  = {slice_y, sh_q[WIDTH-1:1]};
    assign fin_zero = zacc_q & ~slice_y;

    // On the MSB cycle carry_q is still the carry into the MSB.
`ifdef ALU_SERIAL_FLAGS_EN
    assign fin_carry = ctl.arith & slice_cout;
    assign fin_ovf   = ctl.arith & (carry_q ^ slice_cout);
    assign slt_bit   = slice_y ^ (carry_q ^ slice_cout);
`else
    assign fin_carry = 1'b0;
    assign fin_ovf   = 1'b0;
    assign slt_bit   = slice_y;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            sh_q      <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= alu_op_t'(req_op);
                        a_q       <= req_a;
                        b_q       <= req_b;
                        cnt       <= '0;
                        carry_q   <= (alu_op_t'(req_op) == OP_SUB) || (alu_op_t'(req_op) == OP_SLT);
                        zacc_q    <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sh_q   <= next_sh;
                    zacc_q <= fin_zero;
                    if (ctl.arith) begin
                        carry_q <= slice_cout;
                    end
                    if (cnt == CNT_LAST) begin
                        if (op_q == OP_SLT) begin
                            res_data <= {{(WIDTH-1){1'b0}}, slt_bit};
                            res_zero <= ~slt_bit;
                        end else begin
                            res_data <= next_sh;
                            res_zero <= fin_zero;
                        end
                        res_carry <= fin_carry;
                        res_ovf   <= fin_ovf;
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed cases plus randomized ops against
// an arithmetic reference model (honours ALU_SERIAL_FLAGS_EN).
module tb_alu_serial_ctrl;

    localparam int W = 8;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, NAND_ = 3'd5, NOR_ = 3'd6, SLT = 3'd7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_op = '0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_zero;
    logic         res_carry;
    logic         res_ovf;

    int checks = 0;
    int errors = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_carry (res_carry),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic z, output logic c, output logic v);
        logic [W:0] s;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ADD: begin
                s = {1'b0, a} + {1'b0, b};
                d = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            SUB, SLT: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                d = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
                if (op == SLT) begin
`ifdef ALU_SERIAL_FLAGS_EN
                    d = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
`else
                    d = W'(s[W-1]);
`endif
                end
            end
            AND_:    d = a & b;
            OR_:     d = a | b;
            XOR_:    d = a ^ b;
            NAND_:   d = ~(a & b);
            NOR_:    d = ~(a | b);
            default: d = '0;
        endcase
`ifndef ALU_SERIAL_FLAGS_EN
        c = 1'b0;
        v = 1'b0;
`endif
        z = (d == '0);
    endfunction

    // Entered and left on a negedge.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int bp, input string tag);
        logic [W-1:0] ed;
        logic ez, ec, ev;
        int lat;
        model(op, a, b, ed, ez, ec, ev);
        lat = 0;
        while (!req_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " req_ready idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " accepted"}, req_ready, 0);
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_a = W'($urandom);
        req_b = W'($urandom);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, W);
        chk({tag, " data"}, res_data, ed);
        chk({tag, " zero"}, res_zero, ez);
        chk({tag, " carry"}, res_carry, ec);
        chk({tag, " ovf"}, res_ovf, ev);
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_op = 3'($urandom);
            req_a = W'($urandom);
            req_b = W'($urandom);
            @(negedge clk);
            chk({tag, " hold valid"}, res_valid, 1);
            chk({tag, " hold ready"}, req_ready, 0);
            chk({tag, " hold data"}, {res_data, res_zero, res_carry, res_ovf}, {ed, ez, ec, ev});
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk({tag, " release valid"}, res_valid, 0);
        chk({tag, " release ready"}, req_ready, 1);
        res_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset req_ready", req_ready, 1);
        chk("reset res_valid", res_valid, 0);
        chk("reset outputs", {res_data, res_zero, res_carry, res_ovf}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(SUB, 8'h05, 8'h05, 0, "sub_eq");
        run_op(ADD, 8'h7F, 8'h01, 0, "add_ovf");

        req_valid = 1'b1;
        req_op = ADD;
        req_a = 8'h0F;
        req_b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun req_ready", req_ready, 1);
        chk("midrun res_valid", res_valid, 0);
        chk("midrun outputs", {res_data, res_zero, res_carry, res_ovf}, 0);
        reset = 1'b0;
        @(negedge clk);
        run_op(ADD, 8'h0F, 8'h01, 0, "add_after_rst");

        run_op(SLT, 8'h80, 8'h01, 0, "slt_neg");
        run_op(SLT, 8'h01, 8'h80, 0, "slt_pos");
        run_op(AND_, 8'hCA, 8'h0F, 0, "and");
        run_op(OR_, 8'hCA, 8'h0F, 0, "or");
        run_op(XOR_, 8'hCA, 8'h0F, 0, "xor");
        run_op(NAND_, 8'hCA, 8'h0F, 0, "nand");
        run_op(NOR_, 8'hCA, 8'h0F, 0, "nor");
        run_op(SUB, 8'h80, 8'h01, 5, "sub_bp");
        run_op(ADD, 8'hFF, 8'h01, 0, "add_after_bp");

        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
